rtc_write_seq: RTL

Commits the user-edited BCD time/date registers (seconds, minutes, hours, day, month, year) back to the external RTC over its multiplexed Intel-style address/data bus. The edit registers feed their DATA_out values in; this block snapshots them on START and runs a fixed sequence of write transactions. The sequence ends with a commit write that makes the RTC load the new time. It is the write-side counterpart of the bus read path that refreshes the edit registers through DATA_in/Actualizar.

---
 rtl/rtc_write_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rtc_write_seq.sv
// Writes snapshotted BCD time/date to the RTC over its muxed
// address/data bus, then issues the commit write.
//
// Ports:
//   CLK, RESET_N  clock, async active-low reset
//   START         commit request, sampled in IDLE
//   SEG_in..ANO_in  BCD values from the edit registers
//   AD_out, AD_oe   bus address/data and output enable
//   CS_n, WR_n, RD_n, AD_n  bus strobes (AD_n=0 address phase)
//   BUSY, DONE      sequence status, DONE is a 1-cycle pulse
module rtc_write_seq #(
  parameter int         T_LOW       = 10,
  parameter int         T_HIGH      = 6,
  parameter logic [7:0] ADDR_SEG    = 8'h21,
  parameter logic [7:0] ADDR_MIN    = 8'h22,
  parameter logic [7:0] ADDR_HORA   = 8'h23,
  parameter logic [7:0] ADDR_DIA    = 8'h24,
  parameter logic [7:0] ADDR_MES    = 8'h25,
  parameter logic [7:0] ADDR_ANO    = 8'h26,
  parameter logic [7:0] COMMIT_ADDR = 8'hF1,
  parameter logic [7:0] COMMIT_DATA = 8'h00
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic [7:0] SEG_in,
  input  logic [7:0] MIN_in,
  input  logic [7:0] HORA_in,
  input  logic [7:0] DIA_in,
  input  logic [7:0] MES_in,
  input  logic [7:0] ANO_in,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       AD_n,
  output logic       BUSY,
  output logic       DONE
);

  localparam int TMAX = (T_LOW > T_HIGH) ? T_LOW : T_HIGH;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] LOW_LD  = TW'(T_LOW - 1);
  localparam logic [TW-1:0] HIGH_LD = TW'(T_HIGH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LOW,
    S_ADDR_HIGH,
    S_DATA_LOW,
    S_DATA_HIGH,
    S_FINISH
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    index;
  logic [7:0]    seg, min, hora, dia, mes, ano;
  logic [7:0]    cur_addr;
  logic [7:0]    cur_data;

  always_comb begin
    cur_addr = COMMIT_ADDR;
    cur_data = COMMIT_DATA;
    unique case (index)
      3'd0: begin cur_addr = ADDR_SEG;  cur_data = seg;  end
      3'd1: begin cur_addr = ADDR_MIN;  cur_data = min;  end
      3'd2: begin cur_addr = ADDR_HORA; cur_data = hora; end
      3'd3: begin cur_addr = ADDR_DIA;  cur_data = dia;  end
      3'd4: begin cur_addr = ADDR_MES;  cur_data = mes;  end
      3'd5: begin cur_addr = ADDR_ANO;  cur_data = ano;  end
      default: ;
    endcase
  end

  // Bus pins are registered from the current state, so they
  // trail the state by one cycle; phase lengths are unchanged.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_IDLE;
      timer  <= '0;
      index  <= '0;
      seg    <= '0;
      min    <= '0;
      hora   <= '0;
      dia    <= '0;
      mes    <= '0;
      ano    <= '0;
      AD_out <= '0;
      AD_oe  <= 1'b0;
      CS_n   <= 1'b1;
      WR_n   <= 1'b1;
      RD_n   <= 1'b1;
      AD_n   <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      RD_n <= 1'b1;
      unique case (state)
        S_IDLE: begin
          CS_n   <= 1'b1;
          WR_n   <= 1'b1;
          AD_n   <= 1'b1;
          AD_oe  <= 1'b0;
          AD_out <= '0;
          DONE   <= 1'b0;
          if (START) begin
            seg   <= SEG_in;
            min   <= MIN_in;
            hora  <= HORA_in;
            dia   <= DIA_in;
            mes   <= MES_in;
            ano   <= ANO_in;
            index <= '0;
            BUSY  <= 1'b1;
            timer <= LOW_LD;
            state <= S_ADDR_LOW;
          end
        end
        S_ADDR_LOW: begin
          CS_n   <= 1'b0;
          WR_n   <= 1'b0;
          AD_n   <= 1'b0;
          AD_oe  <= 1'b1;
          AD_out <= cur_addr;
          if (timer == '0) begin
            timer <= HIGH_LD;
            state <= S_ADDR_HIGH;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_ADDR_HIGH: begin
          CS_n   <= 1'b1;
          WR_n   <= 1'b1;
          AD_n   <= 1'b0;
          AD_oe  <= 1'b1;
          AD_out <= cur_addr;
          if (timer == '0) begin
            timer <= LOW_LD;
            state <= S_DATA_LOW;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DATA_LOW: begin
          CS_n   <= 1'b0;
          WR_n   <= 1'b0;
          AD_n   <= 1'b1;
          AD_oe  <= 1'b1;
          AD_out <= cur_data;
          if (timer == '0) begin
            timer <= HIGH_LD;
            state <= S_DATA_HIGH;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DATA_HIGH: begin
          CS_n   <= 1'b1;
          WR_n   <= 1'b1;
          AD_n   <= 1'b1;
          AD_oe  <= 1'b1;
          AD_out <= cur_data;
          if (timer == '0) begin
            if (index < 3'd6) begin
              index <= index + 1'b1;
              timer <= LOW_LD;
              state <= S_ADDR_LOW;
            end else begin
              timer <= '0;
              state <= S_FINISH;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_FINISH: begin
          CS_n   <= 1'b1;
          WR_n   <= 1'b1;
          AD_n   <= 1'b1;
          AD_oe  <= 1'b0;
          AD_out <= '0;
          DONE   <= 1'b1;
          BUSY   <= 1'b0;
          timer  <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
